// File: rtl/blit_pkg.sv
// Shared types and address helpers for the blitter memory port.
package blit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_CMD  = 2'd2,
        RD_DATA = 2'd3
    } blit_state_e;

    // Widest address the helpers handle; narrower buses are zero-extended.
    localparam int ADDR_MAX = 32;

    typedef logic [ADDR_MAX-1:0] blit_addr_t;

    function automatic int line_offset_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic blit_addr_t line_of(input blit_addr_t addr, input int offset_bits);
        return addr >> offset_bits;
    endfunction

endpackage

// File: rtl/blit_mem_arb.sv
// IDLE-state port selection: read wins unless a pending write targets the same line.
module blit_mem_arb
    import blit_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 26
) (
    input  logic              blitw_request,
    input  logic [ADDR_W-1:0] blitw_address,
    input  logic              blitr_request,
    input  logic [ADDR_W-1:0] blitr_address,
    output logic              pick_wr,
    output logic              pick_rd
);

    localparam int LINE_OFFSET_BITS = line_offset_bits(LINE_WORDS);

    blit_addr_t w_addr;
    blit_addr_t r_addr;
    logic       hazard;

    always_comb begin
        w_addr = '0;
        r_addr = '0;
        w_addr[ADDR_W-1:0] = blitw_address;
        r_addr[ADDR_W-1:0] = blitr_address;
        // Write-before-read on a shared line keeps the read from fetching stale data.
        hazard  = blitw_request &&
                  (line_of(w_addr, LINE_OFFSET_BITS) == line_of(r_addr, LINE_OFFSET_BITS));
        pick_rd = blitr_request && !hazard;
        pick_wr = blitw_request && (hazard || !blitr_request);
    end

endmodule

// File: rtl/blit_mem_port.sv
// Memory-side responder for the blitter write FIFO and source cache.
// Issues single-word writes and LINE_WORDS-word line reads, one command at a time.
module blit_mem_port
    import blit_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              blitw_request,
    input  logic [ADDR_W-1:0] blitw_address,
    input  logic [31:0]       blitw_wdata,
    input  logic [3:0]        blitw_byte_en,
    output logic              blitw_ack,
    input  logic              blitr_request,
    input  logic [ADDR_W-1:0] blitr_address,
    output logic              blitr_ack,
    output logic [31:0]       blitr_rdata,
    output logic              blitr_valid,
    output logic              blitr_complete,
    output logic              mem_request,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byte_en,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
);

    localparam int              LINE_OFFSET_BITS = line_offset_bits(LINE_WORDS);
    localparam int              CNT_W            = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD       = CNT_W'(LINE_WORDS - 1);

    blit_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_byte_en_q, mem_byte_en_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              complete_q, complete_d;

    logic              pick_wr;
    logic              pick_rd;
    logic [ADDR_W-1:0] wr_word_addr;
    logic [ADDR_W-1:0] rd_line_addr;

    blit_mem_arb #(
        .LINE_WORDS (LINE_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_arb (
        .blitw_request (blitw_request),
        .blitw_address (blitw_address),
        .blitr_request (blitr_request),
        .blitr_address (blitr_address),
        .pick_wr       (pick_wr),
        .pick_rd       (pick_rd)
    );

    assign wr_word_addr = {blitw_address[ADDR_W-1:2], 2'b00};
    assign rd_line_addr = {blitr_address[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_byte_en_q <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            complete_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_byte_en_q <= mem_byte_en_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            complete_q    <= complete_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_byte_en_d = mem_byte_en_q;
        rdata_d       = rdata_q;
        rvalid_d      = 1'b0;
        complete_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // Command fields are captured here and stay frozen until acceptance.
                if (pick_rd) begin
                    state_d       = RD_CMD;
                    mem_write_d   = 1'b0;
                    mem_address_d = rd_line_addr;
                    mem_wdata_d   = '0;
                    mem_byte_en_d = 4'b1111;
                end else if (pick_wr) begin
                    state_d       = WR;
                    mem_write_d   = 1'b1;
                    mem_address_d = wr_word_addr;
                    mem_wdata_d   = blitw_wdata;
                    mem_byte_en_d = blitw_byte_en;
                end
            end
            WR: begin
                if (mem_ready) state_d = IDLE;
            end
            RD_CMD: begin
                if (mem_ready) begin
                    state_d = RD_DATA;
                    cnt_d   = '0;
                end
            end
            RD_DATA: begin
                if (mem_rvalid) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        complete_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_request = (state_q == WR) || (state_q == RD_CMD);
        blitw_ack   = (state_q == WR) && mem_ready;
        blitr_ack   = (state_q == RD_CMD) && mem_ready;
    end

    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_byte_en    = mem_byte_en_q;
    assign blitr_rdata    = rdata_q;
    assign blitr_valid    = rvalid_q;
    assign blitr_complete = complete_q;

endmodule

// File: tb/tb_blit_mem_port.sv
// Scoreboard bench for blit_mem_port: directed scenarios followed by randomized traffic.
module tb_blit_mem_port;

    localparam int LW         = 4;
    localparam int AW         = 26;
    localparam int LINE_BYTES = LW * 4;
    localparam int unsigned AMASK = (1 << AW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          blitw_request;
    logic [AW-1:0] blitw_address;
    logic [31:0]   blitw_wdata;
    logic [3:0]    blitw_byte_en;
    logic          blitw_ack;
    logic          blitr_request;
    logic [AW-1:0] blitr_address;
    logic          blitr_ack;
    logic [31:0]   blitr_rdata;
    logic          blitr_valid;
    logic          blitr_complete;
    logic          mem_request;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_byte_en;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;

    logic          r_rvalid, m_rvalid;
    logic [31:0]   r_rdata, m_rdata;

    assign mem_rvalid = r_rvalid | m_rvalid;
    assign mem_rdata  = r_rvalid ? r_rdata : m_rdata;

    always #5 clock = ~clock;

    blit_mem_port #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .blitw_request  (blitw_request),
        .blitw_address  (blitw_address),
        .blitw_wdata    (blitw_wdata),
        .blitw_byte_en  (blitw_byte_en),
        .blitw_ack      (blitw_ack),
        .blitr_request  (blitr_request),
        .blitr_address  (blitr_address),
        .blitr_ack      (blitr_ack),
        .blitr_rdata    (blitr_rdata),
        .blitr_valid    (blitr_valid),
        .blitr_complete (blitr_complete),
        .mem_request    (mem_request),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_en    (mem_byte_en),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid)
    );

    typedef struct {
        bit          wr;
        int unsigned addr;
        int unsigned wdata;
        int unsigned be;
    } cmd_t;

    typedef struct {
        int unsigned data;
        bit          last;
        int unsigned cyc;
    } rd_t;

    cmd_t sb_cmd[$];
    rd_t  sb_rd[$];

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned lines_acc  = 0;
    int unsigned words_sent = 0;
    bit          resp_en    = 1'b1;
    int          ready_mode = 2;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=event required=no event", name);
    endtask

    function automatic cmd_t wr_cmd(input int unsigned a, input int unsigned d, input int unsigned be);
        cmd_t c;
        c.wr = 1'b1; c.addr = (a & AMASK) & ~32'd3; c.wdata = d; c.be = be & 4'hF;
        return c;
    endfunction

    function automatic cmd_t rd_cmd(input int unsigned a);
        cmd_t c;
        c.wr = 1'b0; c.addr = (a & AMASK) & ~(LINE_BYTES - 1); c.wdata = 0; c.be = 4'hF;
        return c;
    endfunction

    // Memory model: ready pattern plus in-order line data after each accepted read.
    initial begin
        rd_t e;
        r_rvalid  = 1'b0;
        r_rdata   = '0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       mem_ready = ($urandom_range(0, 2) != 0);
                1:       mem_ready = 1'b0;
                default: mem_ready = 1'b1;
            endcase
            r_rvalid = 1'b0;
            if (words_sent < lines_acc * LW && $urandom_range(0, 3) != 0) begin
                r_rvalid = 1'b1;
                r_rdata  = $urandom;
                e.data   = r_rdata;
                e.last   = ((words_sent % LW) == LW - 1);
                e.cyc    = cyc + 1;
                sb_rd.push_back(e);
                words_sent++;
            end
        end
    end

    // Command monitor
    initial begin
        cmd_t c;
        forever begin
            @(negedge clock);
            if (mem_request === 1'b1 && mem_ready === 1'b1) begin
                check("no_cmd_during_read", (words_sent == lines_acc * LW) && (sb_rd.size() == 0), 1);
                if (sb_cmd.size() == 0) begin
                    fail_now("unexpected_cmd");
                end else begin
                    c = sb_cmd.pop_front();
                    check("mem_write", mem_write, c.wr);
                    check("mem_address", mem_address, c.addr);
                    check("mem_byte_en", mem_byte_en, c.be);
                    if (c.wr) check("mem_wdata", mem_wdata, c.wdata);
                    check("blitw_ack", blitw_ack, c.wr);
                    check("blitr_ack", blitr_ack, !c.wr);
                    if (!c.wr && resp_en) lines_acc++;
                end
            end else if (blitw_ack === 1'b1 || blitr_ack === 1'b1) begin
                fail_now("ack_without_accept");
            end
        end
    end

    // Read-return monitor
    initial begin
        rd_t e;
        forever begin
            @(negedge clock);
            if (blitr_valid === 1'b1) begin
                if (sb_rd.size() == 0) begin
                    fail_now("unexpected_blitr_valid");
                end else begin
                    e = sb_rd.pop_front();
                    check("blitr_rdata", blitr_rdata, e.data);
                    check("blitr_complete", blitr_complete, e.last);
                    check("blitr_latency", cyc, e.cyc);
                end
            end else if (blitr_complete === 1'b1) begin
                fail_now("complete_without_valid");
            end
        end
    end

    task automatic do_write(input int unsigned a, input int unsigned d, input int unsigned be);
        int n = 0;
        blitw_address = a[AW-1:0];
        blitw_wdata   = d;
        blitw_byte_en = be[3:0];
        blitw_request = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (blitw_ack !== 1'b1 && n < 2000);
        if (n >= 2000) fail_now("blitw_ack_timeout");
        @(posedge clock);
        #1;
        blitw_request = 1'b0;
    endtask

    task automatic do_read(input int unsigned a);
        int n = 0;
        blitr_address = a[AW-1:0];
        blitr_request = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (blitr_ack !== 1'b1 && n < 2000);
        if (n >= 2000) fail_now("blitr_ack_timeout");
        @(posedge clock);
        #1;
        blitr_request = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_cmd.size() != 0 || sb_rd.size() != 0 || words_sent != lines_acc * LW) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) fail_now("drain_timeout");
        repeat (3) @(negedge clock);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_request"}, mem_request, 0);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_mem_address"}, mem_address, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_mem_byte_en"}, mem_byte_en, 0);
        check({tag, "_acks"}, {blitw_ack, blitr_ack}, 0);
        check({tag, "_blitr_valid"}, {blitr_valid, blitr_complete}, 0);
        check({tag, "_blitr_rdata"}, blitr_rdata, 0);
    endtask

    task automatic manual_word(input bit v, input int unsigned d, input bit last, input bit expect_out);
        rd_t e;
        @(posedge clock);
        #1;
        m_rvalid = v;
        m_rdata  = d;
        if (v && expect_out) begin
            e.data = d; e.last = last; e.cyc = cyc + 1;
            sb_rd.push_back(e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned wa, ra, d, be;
        int          kind;
        bit          haz;
        cmd_t        exp_c;

        reset = 1'b1;
        blitw_request = 1'b0; blitw_address = '0; blitw_wdata = '0; blitw_byte_en = '0;
        blitr_request = 1'b0; blitr_address = '0;
        m_rvalid = 1'b0; m_rdata = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single write, memory ready after 3 cycles.
        ready_mode = 1;
        sb_cmd.push_back(wr_cmd(32'h104, 32'hAABBCCDD, 4'b0010));
        fork
            do_write(32'h104, 32'hAABBCCDD, 4'b0010);
            begin
                repeat (3) @(posedge clock);
                ready_mode = 2;
            end
        join
        @(negedge clock);
        check("write_idle_mem_request", mem_request, 0);
        check("write_idle_ack", blitw_ack, 0);
        drain();

        // Line read with a 2-cycle gap after word 2.
        resp_en = 1'b0;
        sb_cmd.push_back(rd_cmd(32'h200));
        do_read(32'h200);
        manual_word(1, 1, 0, 1);
        manual_word(1, 2, 0, 1);
        manual_word(0, 0, 0, 1);
        manual_word(0, 0, 0, 1);
        manual_word(1, 3, 0, 1);
        manual_word(1, 4, 1, 1);
        manual_word(0, 0, 0, 1);
        drain();
        resp_en = 1'b1;

        // Priority: different lines, read first.
        sb_cmd.push_back(rd_cmd(32'h1000));
        sb_cmd.push_back(wr_cmd(32'h2000, 32'h12345678, 4'hF));
        fork
            do_read(32'h1000);
            do_write(32'h2000, 32'h12345678, 4'hF);
        join
        drain();

        // Hazard: same line, write first.
        sb_cmd.push_back(wr_cmd(32'h300C, 32'hCAFEF00D, 4'b1001));
        sb_cmd.push_back(rd_cmd(32'h3004));
        fork
            do_read(32'h3004);
            do_write(32'h300C, 32'hCAFEF00D, 4'b1001);
        join
        drain();

        // Reset mid-burst after 2 words, then stray words.
        resp_en = 1'b0;
        sb_cmd.push_back(rd_cmd(32'h4000));
        do_read(32'h4000);
        manual_word(1, 32'h11, 0, 1);
        manual_word(1, 32'h22, 0, 1);
        manual_word(0, 0, 0, 1);
        @(negedge clock);
        reset = 1'b1;
        manual_word(1, 32'h33, 0, 0);
        @(negedge clock);
        check_outputs_zero("midreset");
        reset = 1'b0;
        manual_word(1, 32'h44, 0, 0);
        manual_word(0, 0, 0, 0);
        repeat (4) @(negedge clock);
        check("post_reset_valid", {blitr_valid, blitr_complete}, 0);
        resp_en = 1'b1;
        sb_cmd.push_back(wr_cmd(32'h5008, 32'h0BADBEEF, 4'b0110));
        do_write(32'h5008, 32'h0BADBEEF, 4'b0110);
        drain();

        // Stall: command held constant while mem_ready is low.
        ready_mode = 1;
        exp_c = wr_cmd(32'h6010, 32'h5A5AA5A5, 4'b1100);
        sb_cmd.push_back(exp_c);
        fork
            do_write(32'h6010, 32'h5A5AA5A5, 4'b1100);
            begin
                int n = 0;
                do begin
                    @(negedge clock);
                    n++;
                end while (mem_request !== 1'b1 && n < 20);
                for (int i = 0; i < 10; i++) begin
                    check("stall_mem_request", mem_request, 1);
                    check("stall_mem_write", mem_write, 1);
                    check("stall_mem_address", mem_address, exp_c.addr);
                    check("stall_mem_wdata", mem_wdata, exp_c.wdata);
                    check("stall_mem_byte_en", mem_byte_en, exp_c.be);
                    check("stall_blitw_ack", blitw_ack, 0);
                    @(negedge clock);
                end
                ready_mode = 2;
            end
        join
        drain();

        // Randomized traffic.
        ready_mode = 0;
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 2);
            ra   = $urandom & AMASK;
            wa   = $urandom & AMASK;
            if (kind == 2 && $urandom_range(0, 1) == 1)
                wa = (ra & ~(LINE_BYTES - 1)) | $urandom_range(0, LINE_BYTES - 1);
            d  = $urandom;
            be = $urandom_range(0, 15);
            if (kind == 0) begin
                sb_cmd.push_back(wr_cmd(wa, d, be));
                do_write(wa, d, be);
            end else if (kind == 1) begin
                sb_cmd.push_back(rd_cmd(ra));
                do_read(ra);
            end else begin
                haz = ((wa / LINE_BYTES) == (ra / LINE_BYTES));
                if (haz) begin
                    sb_cmd.push_back(wr_cmd(wa, d, be));
                    sb_cmd.push_back(rd_cmd(ra));
                end else begin
                    sb_cmd.push_back(rd_cmd(ra));
                    sb_cmd.push_back(wr_cmd(wa, d, be));
                end
                fork
                    do_read(ra);
                    do_write(wa, d, be);
                join
            end
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blit_mem_port.md
Name: blit_mem_port

Overview:
- Memory-side responder for the blitter's two bus masters: the write port (fed by the blitter write FIFO) and the read port (fed by the blitter source cache).
- Arbitrates between the two ports and issues single-word writes and fixed-length line reads to the SDRAM controller command interface.
- Returns read data to the cache with per-word valid and an end-of-line complete strobe.
- Sits between the blitter and the SDRAM arbiter.

Parameters:
- LINE_WORDS, 4: 32-bit words per read burst; must be a power of 2, range 2..16.
- ADDR_W, 26: byte address width.

Ports:
- clock  in  1  system clock
- reset  in  1  reset reset, synchronous, active-high; clock clock
- blitw_request  in  1  write pending; address, data and byte_en are stable while high
- blitw_address  in  ADDR_W  word-aligned byte address; bits[1:0] ignored
- blitw_wdata  in  32  write data
- blitw_byte_en  in  4  byte lane enables
- blitw_ack  out  1  one-cycle pulse: write accepted, FIFO pops
- blitr_request  in  1  line read pending
- blitr_address  in  ADDR_W  line-aligned address; low log2(LINE_WORDS)+2 bits ignored
- blitr_ack  out  1  one-cycle pulse: read command accepted
- blitr_rdata  out  32  read data word
- blitr_valid  out  1  blitr_rdata valid this cycle
- blitr_complete  out  1  high with the last valid word of a line
- mem_request  out  1  command valid to the SDRAM controller
- mem_write  out  1  1 = write, 0 = burst read
- mem_address  out  ADDR_W  command address, low 2 bits forced to 0
- mem_wdata  out  32  write data
- mem_byte_en  out  4  write byte enables; 4'b1111 on reads
- mem_ready  in  1  command accepted when mem_request && mem_ready
- mem_rdata  in  32  returned read word
- mem_rvalid  in  1  read word valid; exactly LINE_WORDS per read, in order, may have gaps

Behaviour:
- Reset: all outputs 0; state IDLE; word counter 0. Reset mid-burst abandons the burst. Any remaining mem_rvalid words are ignored until the next read is issued.
- States:
  - IDLE: choose a port.
  - WR: hold write command.
  - RD_CMD: hold read command.
  - RD_DATA: collect LINE_WORDS words.
- Arbitration in IDLE:
  - Read has priority over write.
  - Exception: if blitw_request is high and the write's line address (address[ADDR_W-1:log2(LINE_WORDS)+2]) equals the read's line address, the write goes first (RAW hazard).
  - Otherwise go to RD_CMD if blitr_request, else WR if blitw_request, else stay in IDLE.
- The command is registered on entry to WR/RD_CMD. mem_request rises the cycle after the decision and is held with constant fields until mem_ready.
- WR: on mem_request && mem_ready, pulse blitw_ack that same cycle, drop mem_request next cycle, return to IDLE. A write completes from the port's view at acceptance; there is no write response. Back-to-back writes cost 2 cycles each minimum.
- RD_CMD: on acceptance, pulse blitr_ack that cycle, clear counter, go to RD_DATA.
- RD_DATA:
  - Each mem_rvalid registers mem_rdata into blitr_rdata and sets blitr_valid on the next cycle (1-cycle latency), then increments the counter.
  - On word LINE_WORDS-1, blitr_complete is asserted alongside that blitr_valid; the state returns to IDLE the same cycle.
  - Counter width is log2(LINE_WORDS) and wraps naturally.
- Write requests are never serviced during RD_CMD/RD_DATA. At most one outstanding command exists at a time.
- mem_rvalid outside RD_DATA is ignored.
- Request drop before ack is a protocol violation by the master. The block keeps its latched command and completes it anyway.
- blitr_request held high after complete: re-arbitrated in IDLE as a new line read.
- Simultaneous requests with a line hazard: the write completes first, the read is taken on the next IDLE.

Decomposition:
- Shared package blit_pkg: state enum (IDLE, WR, RD_CMD, RD_DATA), LINE_OFFSET_BITS = log2(LINE_WORDS)+2, function line_of(addr).
- Sub-module blit_mem_arb: purely combinational IDLE decision (read/write select, hazard compare).
- FSM, command registers and read-return path live in the top.

Test Plan:
- Single write: blitw_request, addr 0x000104, data 0xAABBCCDD, be 4'b0010; mem_ready after 3 cycles.
  Required: mem_address=0x000104, mem_write=1, mem_byte_en=0010, one blitw_ack pulse on the accept cycle, IDLE afterward.
- Line read, LINE_WORDS=4: blitr_request addr 0x000200; mem_ready immediately; rvalid words 1,2,3,4 with a 2-cycle gap after word 2.
  Required: blitr_ack once; blitr_valid four times, each one cycle after its rvalid; blitr_complete only with word 4.
- Priority: both requests, read 0x001000, write 0x002000.
  Required: read issued first, write issued after complete; blitw_ack only after blitr_complete.
- Hazard: both requests, read 0x003004, write 0x00300C (same line).
  Required: write accepted first, then the read command at 0x003000.
- Reset during RD_DATA after 2 words, then 2 stray rvalids.
  Required: no blitr_valid/complete; outputs 0; a new write is serviced normally.
- Stall: mem_ready low for 10 cycles on a write.
  Required: mem_request and all command fields stay constant; blitw_ack stays low until mem_ready.
